// File: rtl/pf_vf_route_lookup.sv
// pf_vf_route_lookup: per-packet PF/VF routing lookup ahead of the PF/VF MUX.
// The SOP beat's (pf, vf, vf_active) tag is matched against a static table.
// The lowest matching entry wins; a miss routes to DEFAULT_PORT.
// Every beat of the packet carries the resolved port through one registered
// valid/ready stage.
// Optional feature macro: OFS_PF_VF_ROUTE_MISS_CNT_EN adds a saturating
// miss_cnt output.
module pf_vf_route_lookup #(
    parameter int unsigned NUM_ENTRIES  = 8,
    parameter int unsigned PF_WIDTH     = 3,
    parameter int unsigned VF_WIDTH     = 11,
    parameter int unsigned NUM_PORT     = 4,
    parameter int unsigned DATA_W       = 512,
    localparam int unsigned PORT_W      = (NUM_PORT < 2) ? 1 : $clog2(NUM_PORT),
    parameter logic [NUM_ENTRIES*PF_WIDTH-1:0] TBL_PF        = '0,
    parameter logic [NUM_ENTRIES*VF_WIDTH-1:0] TBL_VF        = '0,
    parameter logic [NUM_ENTRIES-1:0]          TBL_VF_ACTIVE = '0,
    parameter logic [NUM_ENTRIES*PORT_W-1:0]   TBL_PORT      = '0,
    parameter int unsigned DEFAULT_PORT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [PF_WIDTH-1:0] in_pf,
    input  logic [VF_WIDTH-1:0] in_vf,
    input  logic                in_vf_active,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sop,
    output logic                out_eop,
    output logic [PORT_W-1:0]   out_port,
    output logic                out_miss,
    output logic [DATA_W-1:0]   out_data
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
    ,
    output logic [15:0]         miss_cnt
`endif
);

    typedef enum logic {IDLE, IN_PKT} state_t;

    localparam logic [PORT_W-1:0] DEF_PORT = PORT_W'(DEFAULT_PORT);

    state_t              r_state;
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [PORT_W-1:0]   r_out_port;
    logic                r_out_miss;
    logic [DATA_W-1:0]   r_out_data;
    logic [PORT_W-1:0]   r_cur_port;
    logic                r_cur_miss;
    logic                r_err_sop;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_hit;
    logic [PORT_W-1:0]   w_hit_port;
    logic [PORT_W-1:0]   w_lu_port;
    logic                w_lu_miss;

    // A destination port outside the MUX range is a table configuration error.
    for (genvar g = 0; g < int'(NUM_ENTRIES); g++) begin : g_port_chk
        if (int'(TBL_PORT[g*PORT_W +: PORT_W]) >= int'(NUM_PORT)) begin : g_bad
            $error("pf_vf_route_lookup: TBL_PORT entry %0d exceeds NUM_PORT", g);
        end
    end

    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;

    // Table search on the current input tag; the lowest matching index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_port = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!w_hit &&
                in_pf == TBL_PF[i*PF_WIDTH +: PF_WIDTH] &&
                in_vf_active == TBL_VF_ACTIVE[i] &&
                (!in_vf_active || in_vf == TBL_VF[i*VF_WIDTH +: VF_WIDTH])) begin
                w_hit      = 1'b1;
                w_hit_port = TBL_PORT[i*PORT_W +: PORT_W];
            end
        end
        w_lu_port = w_hit ? w_hit_port : DEF_PORT;
        w_lu_miss = ~w_hit;
    end

    // Packet FSM plus the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_port  <= '0;
            r_out_miss  <= 1'b0;
            r_out_data  <= '0;
            r_cur_port  <= '0;
            r_cur_miss  <= 1'b0;
            r_err_sop   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= in_sop;
            r_out_eop   <= in_eop;
            r_out_data  <= in_data;
            if (in_sop) begin
                // A SOP is always a fresh lookup, even if it interrupts a packet.
                r_out_port <= w_lu_port;
                r_out_miss <= w_lu_miss;
                r_cur_port <= w_lu_port;
                r_cur_miss <= w_lu_miss;
                r_state    <= in_eop ? IDLE : IN_PKT;
                if (r_state == IN_PKT) begin
                    r_err_sop <= 1'b1;
                end
            end else begin
                case (r_state)
                    IN_PKT: begin
                        r_out_port <= r_cur_port;
                        r_out_miss <= r_cur_miss;
                        if (in_eop) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_out_port <= DEF_PORT;
                        r_out_miss <= 1'b1;
                        r_err_sop  <= 1'b1;
                    end
                endcase
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
    logic [15:0] r_miss_cnt;

    // Saturating count of missed packets, taken on the SOP beat's output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_sop && r_out_miss &&
                     r_miss_cnt != 16'hFFFF) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign miss_cnt = r_miss_cnt;
`endif

    // The protocol-error flag only clears on reset.
    a_err_sop_sticky: assert property (@(posedge clk) disable iff (rst)
        r_err_sop |=> r_err_sop);

    // A stalled output beat must not change.
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (r_out_valid && !out_ready) |=>
        (r_out_valid && $stable(r_out_data) && $stable(r_out_port) &&
         $stable(r_out_miss) && $stable(r_out_sop) && $stable(r_out_eop)));

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_port  = r_out_port;
    assign out_miss  = r_out_miss;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_pf_vf_route_lookup.sv
// Directed testbench for pf_vf_route_lookup.
// Table: e0 pf0 act0 ->p0, e1 pf0 vf3 act1 ->p1, e2 pf1 act0 ->p2, and
// e3 pf1 act0 ->p1, which e2 shadows. DEFAULT_PORT is 3.
module tb_pf_vf_route_lookup;

    localparam int unsigned NE  = 4;
    localparam int unsigned PFW = 3;
    localparam int unsigned VFW = 11;
    localparam int unsigned NP  = 4;
    localparam int unsigned DW  = 32;
    localparam logic [NE*PFW-1:0] T_PF   = {3'd1, 3'd1, 3'd0, 3'd0};
    localparam logic [NE*VFW-1:0] T_VF   = {11'd0, 11'd0, 11'd3, 11'd0};
    localparam logic [NE-1:0]     T_ACT  = 4'b0010;
    localparam logic [NE*2-1:0]   T_PORT = {2'd1, 2'd2, 2'd1, 2'd0};

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_sop, in_eop, in_vf_active;
    logic [PFW-1:0] in_pf;
    logic [VFW-1:0] in_vf;
    logic [DW-1:0]  in_data;
    logic           out_valid, out_ready, out_sop, out_eop, out_miss;
    logic [1:0]     out_port;
    logic [DW-1:0]  out_data;
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
    logic [15:0]    miss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pf_vf_route_lookup #(
        .NUM_ENTRIES  (NE),
        .PF_WIDTH     (PFW),
        .VF_WIDTH     (VFW),
        .NUM_PORT     (NP),
        .DATA_W       (DW),
        .TBL_PF       (T_PF),
        .TBL_VF       (T_VF),
        .TBL_VF_ACTIVE(T_ACT),
        .TBL_PORT     (T_PORT),
        .DEFAULT_PORT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_pf       (in_pf),
        .in_vf       (in_vf),
        .in_vf_active(in_vf_active),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_port    (out_port),
        .out_miss    (out_miss),
        .out_data    (out_data)
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        ,
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic sop, input logic eop,
                            input logic [1:0] port, input logic miss, input logic [DW-1:0] data);
        chk($sformatf("%s.valid", tag), 64'(out_valid), 64'(1'b1));
        chk($sformatf("%s.sop", tag),   64'(out_sop),   64'(sop));
        chk($sformatf("%s.eop", tag),   64'(out_eop),   64'(eop));
        chk($sformatf("%s.port", tag),  64'(out_port),  64'(port));
        chk($sformatf("%s.miss", tag),  64'(out_miss),  64'(miss));
        chk($sformatf("%s.data", tag),  64'(out_data),  64'(data));
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single cycle (out_ready is high, so it is taken).
    task automatic send(input logic sop, input logic eop, input logic [PFW-1:0] pf,
                        input logic [VFW-1:0] vf, input logic act, input logic [DW-1:0] data);
        in_valid     = 1'b1;
        in_sop       = sop;
        in_eop       = eop;
        in_pf        = pf;
        in_vf        = vf;
        in_vf_active = act;
        in_data      = data;
        cyc();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_pf = '0; in_vf = '0; in_vf_active = 1'b0; in_data = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) cyc();
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.sop",   64'(out_sop),   64'(0));
        chk("rst.eop",   64'(out_eop),   64'(0));
        chk("rst.port",  64'(out_port),  64'(0));
        chk("rst.miss",  64'(out_miss),  64'(0));
        chk("rst.data",  64'(out_data),  64'(0));
        rst = 1'b0;
        cyc();
        chk("rst.in_ready", 64'(in_ready), 64'(1));
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        chk("rst.miss_cnt", 64'(miss_cnt), 64'(0));
`endif

        // Single-beat pf1: e2 and e3 both match, lowest index gives port 2
        send(1'b1, 1'b1, 3'd1, 11'd7, 1'b0, 32'hA1);
        chk_beat("single", 1'b1, 1'b1, 2'd2, 1'b0, 32'hA1);
        cyc();
        chk("single.drain", 64'(out_valid), 64'(0));

        // Four-beat VF packet, back to back
        for (int k = 0; k < 4; k++) begin
            send(k == 0, k == 3, 3'd0, 11'd3, 1'b1, 32'hB0 + 32'(k));
            chk_beat($sformatf("vf4.b%0d", k), k == 0, k == 3, 2'd1, 1'b0, 32'hB0 + 32'(k));
        end

        // Miss packet; the later beat's tag fields are ignored
        send(1'b1, 1'b0, 3'd2, 11'd0, 1'b0, 32'hC0);
        chk_beat("miss.b0", 1'b1, 1'b0, 2'd3, 1'b1, 32'hC0);
        send(1'b0, 1'b1, 3'd2, 11'd5, 1'b1, 32'hC1);
        chk_beat("miss.b1", 1'b0, 1'b1, 2'd3, 1'b1, 32'hC1);

        // VF mismatch on a VF entry misses; the VF is ignored for PF entries
        send(1'b1, 1'b1, 3'd0, 11'd4, 1'b1, 32'hD0);
        chk_beat("vfmis", 1'b1, 1'b1, 2'd3, 1'b1, 32'hD0);
        send(1'b1, 1'b1, 3'd0, 11'd99, 1'b0, 32'hD1);
        chk_beat("pfhit", 1'b1, 1'b1, 2'd0, 1'b0, 32'hD1);
        cyc();
        chk("pfhit.drain", 64'(out_valid), 64'(0));
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        chk("cnt.two", 64'(miss_cnt), 64'(2));
`endif

        // Downstream backpressure for three cycles mid-packet
        send(1'b1, 1'b0, 3'd1, 11'd7, 1'b0, 32'hE0);
        chk_beat("stall.b0", 1'b1, 1'b0, 2'd2, 1'b0, 32'hE0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 32'hE1;
        #1;
        chk("stall.in_ready0", 64'(in_ready), 64'(0));
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_beat($sformatf("stall.hold%0d", k), 1'b1, 1'b0, 2'd2, 1'b0, 32'hE0);
            chk($sformatf("stall.in_ready%0d", k), 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("stall.in_ready1", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        chk_beat("stall.b1", 1'b0, 1'b0, 2'd2, 1'b0, 32'hE1);
        send(1'b0, 1'b1, 3'd0, 11'd0, 1'b0, 32'hE2);
        chk_beat("stall.b2", 1'b0, 1'b1, 2'd2, 1'b0, 32'hE2);
        cyc();
        chk("stall.drain", 64'(out_valid), 64'(0));

        // SOP inside a packet is looked up afresh; non-SOP in IDLE goes to default
        send(1'b1, 1'b0, 3'd0, 11'd3, 1'b1, 32'hF0);
        chk_beat("err.b0", 1'b1, 1'b0, 2'd1, 1'b0, 32'hF0);
        send(1'b1, 1'b1, 3'd1, 11'd0, 1'b0, 32'hF1);
        chk_beat("err.resop", 1'b1, 1'b1, 2'd2, 1'b0, 32'hF1);
        send(1'b0, 1'b1, 3'd0, 11'd3, 1'b1, 32'hF2);
        chk_beat("err.idle", 1'b0, 1'b1, 2'd3, 1'b1, 32'hF2);
        cyc();
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        chk("cnt.nosop", 64'(miss_cnt), 64'(2));
`endif

        // Reset on beat 2 of a four-beat packet
        send(1'b1, 1'b0, 3'd0, 11'd3, 1'b1, 32'h10);
        chk_beat("rstmid.b0", 1'b1, 1'b0, 2'd1, 1'b0, 32'h10);
        send(1'b0, 1'b0, 3'd0, 11'd3, 1'b1, 32'h11);
        chk_beat("rstmid.b1", 1'b0, 1'b0, 2'd1, 1'b0, 32'h11);
        in_valid = 1'b1; in_data = 32'h12;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rstmid.valid",    64'(out_valid), 64'(0));
        chk("rstmid.port",     64'(out_port),  64'(0));
        chk("rstmid.data",     64'(out_data),  64'(0));
        chk("rstmid.in_ready", 64'(in_ready),  64'(1));
`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        chk("rstmid.miss_cnt", 64'(miss_cnt), 64'(0));
`endif
        send(1'b1, 1'b1, 3'd1, 11'd2, 1'b0, 32'h20);
        chk_beat("rstmid.new", 1'b1, 1'b1, 2'd2, 1'b0, 32'h20);
        cyc();

`ifdef OFS_PF_VF_ROUTE_MISS_CNT_EN
        // Miss counter increment and saturation
        send(1'b1, 1'b1, 3'd2, 11'd0, 1'b0, 32'h30);
        cyc();
        chk("cnt.one", 64'(miss_cnt), 64'(1));
        for (int k = 0; k < 65540; k++) begin
            send(1'b1, 1'b1, 3'd3, 11'd0, 1'b0, 32'(k));
        end
        cyc();
        chk("cnt.sat", 64'(miss_cnt), 64'(16'hFFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
